// File: rtl/fsm_serial_pkg.sv
// Shared definitions for the serial line FSMs (transmitter and receiver).
package fsm_serial_pkg;

  // Frame phases, in the order they appear on the line.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clocks occupied by one complete frame: start + data + optional parity + stop.
  function automatic int frame_clks(input int data_bits, input int parity_en, input int baud_div);
    return (1 + data_bits + parity_en + 1) * baud_div;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: tick_o is high in the last clock of every BAUD_DIV-clock
// bit period. clear_i holds the counter at zero so a new frame starts aligned.
// last_next_o says the coming clock will be the last one of its bit period,
// which lets the owner register outputs that must line up with that clock.
module baud_tick #(
  parameter int BAUD_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o,
  output logic last_next_o
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at the end of each bit period, or restart on clear.
  always_comb begin
    tick_o      = (cnt_q == LAST);
    cnt_d       = (clear_i || tick_o) ? '0 : cnt_q + 1'b1;
    last_next_o = (cnt_d == LAST);
  end

  // Counter register.
  // NOTE: clocked state always uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fsm_serial_tx.sv
// Byte-serial transmitter: start bit, DATA_BITS data bits LSB first, optional
// odd parity, one stop bit. Words arrive on a valid/ready handshake; a word can
// be accepted in the last clock of a stop bit so frames run back to back.
module fsm_serial_tx
  import fsm_serial_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1,
  parameter int BAUD_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 last_next;
  logic                 accept;
  logic                 baud_clear;

  // The bit timer idles at zero so the start bit gets a full period.
  assign baud_clear = (state_q == IDLE);

  baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (baud_clear),
    .tick_o      (tick),
    .last_next_o (last_next)
  );

  // Next-state logic; registered outputs are derived from the next state so
  // they change on the same edge as the state.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_d    = bit_q;

    in_ready = !reset && ((state_q == IDLE) || ((state_q == STOP) && tick));
    accept   = in_valid && in_ready;

    if (accept) begin
      state_d  = START;
      shift_d  = in_data;
      parity_d = ~^in_data;
      bit_d    = '0;
    end else begin
      case (state_q)
        IDLE: ;
        START: begin
          if (tick) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) state_d = STOP;
        end
        STOP: begin
          if (tick) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    case (state_d)
      IDLE:    out_d = LINE_IDLE;
      START:   out_d = START_BIT;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = parity_d;
      default: out_d = STOP_BIT;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && last_next;
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      // NOTE: the data shift register is cleared too; it is small and a known value eases debug.
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      out_q    <= LINE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bit_q    <= bit_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: three configurations side by side, a per-clock line
// model built from the frame rules, a hand table for one default frame, and
// hand sequences for back-to-back, slow baud, 1-bit data and mid-frame reset.
module tb_fsm_serial_tx;

  localparam int NB [3] = '{8, 8, 1};   // data bits per instance
  localparam int PE [3] = '{1, 0, 1};   // parity enable per instance
  localparam int BD [3] = '{1, 4, 1};   // clocks per bit per instance
  localparam int QD = 256;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] vld   = '0;
  logic [7:0] dat0  = '0;
  logic [7:0] dat1  = '0;
  logic [0:0] dat2  = '0;
  logic [2:0] rdy, line, bsy, dn;
  logic [2:0] s_rdy, s_line, s_bsy, s_dn;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected line level for each upcoming clock, one FIFO per instance.
  bit mq [3][QD];
  int hd [3] = '{0, 0, 0};
  int tl [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  fsm_serial_tx #(.DATA_BITS(8), .PARITY_EN(1), .BAUD_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(dat0), .in_valid(vld[0]),
    .in_ready(rdy[0]), .out(line[0]), .busy(bsy[0]), .done(dn[0]));

  fsm_serial_tx #(.DATA_BITS(8), .PARITY_EN(0), .BAUD_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .in_data(dat1), .in_valid(vld[1]),
    .in_ready(rdy[1]), .out(line[1]), .busy(bsy[1]), .done(dn[1]));

  fsm_serial_tx #(.DATA_BITS(1), .PARITY_EN(1), .BAUD_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .in_data(dat2), .in_valid(vld[2]),
    .in_ready(rdy[2]), .out(line[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int k);
    case (k)
      0:       return {8'h00, dat0};
      1:       return {8'h00, dat1};
      default: return {15'h0000, dat2};
    endcase
  endfunction

  // Append one frame, clock by clock, from the line-format rules.
  task automatic push_frame(input int k, input logic [15:0] w);
    logic [15:0] m;
    int          ones;
    logic        lvl;
    m    = 16'hFFFF >> (16 - NB[k]);
    ones = $countones(w & m);
    for (int s = 0; s < NB[k] + PE[k] + 2; s++) begin
      if (s == 0)                              lvl = 1'b0;
      else if (s <= NB[k])                     lvl = w[s-1];
      else if (PE[k] != 0 && s == NB[k] + 1)   lvl = ((ones % 2) == 0);
      else                                     lvl = 1'b1;
      repeat (BD[k]) begin
        mq[k][tl[k] % QD] = lvl;
        tl[k]++;
      end
    end
  endtask

  // One clock: compare every instance with the model, then advance the model.
  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick_cycle();
    int          sz [3];
    logic [2:0]  acc;
    logic [15:0] w [3];
    logic        e_out;
    #1;
    s_rdy  = rdy;
    s_line = line;
    s_bsy  = bsy;
    s_dn   = dn;
    for (int k = 0; k < 3; k++) begin
      sz[k] = tl[k] - hd[k];
      e_out = (sz[k] > 0) ? mq[k][hd[k] % QD] : 1'b1;
      check($sformatf("line%0d", k),  32'(line[k]), 32'(e_out));
      check($sformatf("busy%0d", k),  32'(bsy[k]),  32'(sz[k] > 0));
      check($sformatf("done%0d", k),  32'(dn[k]),   32'(sz[k] == 1));
      check($sformatf("ready%0d", k), 32'(rdy[k]),  32'(!reset && sz[k] <= 1));
      acc[k] = vld[k] && !reset && (sz[k] <= 1);
      w[k]   = word_of(k);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        hd[k] = tl[k];
      end else begin
        if (sz[k] > 0) hd[k]++;
        if (acc[k]) push_frame(k, w[k]);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e_out;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  initial begin
    vec_t        tbl [13];
    logic [21:0] r_rdy;
    logic [22:0] r_line, r_done;
    logic [41:0] r1_line;
    logic [9:0]  slots;
    logic [5:0]  r2_line, r2_done;
    int          mism, d_cnt, d_at, b_cnt;

    // Default-configuration frame for 0x4B; valid pulses mid-frame must be ignored.
    tbl[0]  = '{1'b1, 8'h4B, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset: the cycle after the first reset edge shows reset values everywhere.
    @(posedge clk);
    @(negedge clk);
    tick_cycle();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      vld[0] = tbl[i].v;
      dat0   = tbl[i].d;
      #1;
      check($sformatf("tbl[%0d].out", i),   32'(line[0]), 32'(tbl[i].e_out));
      check($sformatf("tbl[%0d].busy", i),  32'(bsy[0]),  32'(tbl[i].e_busy));
      check($sformatf("tbl[%0d].done", i),  32'(dn[0]),   32'(tbl[i].e_done));
      check($sformatf("tbl[%0d].ready", i), 32'(rdy[0]),  32'(tbl[i].e_ready));
      tick_cycle();
    end
    vld[0] = 1'b0;

    // Back to back: 0x00 then 0xFF with valid held high.
    for (int c = 0; c <= 22; c++) begin
      vld[0] = (c <= 11);
      dat0   = (c == 0) ? 8'h00 : 8'hFF;
      tick_cycle();
      if (c < 22) r_rdy[c] = s_rdy[0];
      r_line[c] = s_line[0];
      r_done[c] = s_dn[0];
    end
    vld[0] = 1'b0;
    check("b2b ready cycles",   32'(r_rdy),     32'h000801);
    check("b2b parity 0x00",    32'(r_line[10]), 32'd1);
    check("b2b second start",   32'(r_line[12]), 32'd0);
    check("b2b parity 0xFF",    32'(r_line[21]), 32'd1);
    check("b2b done cycles",    32'(r_done),    32'h400800);

    // Slow baud, no parity: 0xA5 held 4 clocks per bit, 40-clock frame.
    slots = 10'b1101001010;
    d_cnt = 0; d_at = -1; b_cnt = 0;
    for (int c = 0; c <= 41; c++) begin
      vld[1] = (c == 0);
      dat1   = (c == 0) ? 8'hA5 : 8'($urandom);
      tick_cycle();
      r1_line[c] = s_line[1];
      if (s_dn[1]) begin d_cnt++; d_at = c; end
      if (s_bsy[1]) b_cnt++;
    end
    vld[1] = 1'b0;
    mism = 0;
    for (int c = 1; c <= 40; c++) if (r1_line[c] !== slots[(c-1)/4]) mism++;
    check("baud4 bit errors",  32'(mism),  32'd0);
    check("baud4 done count",  32'(d_cnt), 32'd1);
    check("baud4 done cycle",  32'(d_at),  32'd40);
    check("baud4 busy clocks", 32'(b_cnt), 32'd40);

    // One data bit: 0, 1, parity 0, stop 1.
    for (int c = 0; c <= 5; c++) begin
      vld[2] = (c == 0);
      dat2   = 1'b1;
      tick_cycle();
      r2_line[c] = s_line[2];
      r2_done[c] = s_dn[2];
    end
    vld[2] = 1'b0;
    check("1bit frame", 32'(r2_line[4:1]), 32'b1010);
    check("1bit done",  32'(r2_done),      32'b010000);

    // Reset during the 5th data bit of 0x3C, then a fresh word.
    d_cnt = 0;
    for (int c = 0; c <= 34; c++) begin
      vld[0] = (c == 0) || (c == 21);
      dat0   = (c == 0) ? 8'h3C : 8'h96;
      reset  = (c == 6);
      tick_cycle();
      if (c == 6) check("rst ready low", 32'(s_rdy[0]), 32'd0);
      if (c == 7) begin
        check("rst line idle", 32'(s_line[0]), 32'd1);
        check("rst busy low",  32'(s_bsy[0]),  32'd0);
      end
      if (c < 21 && s_dn[0]) d_cnt++;
      if (c == 32) check("post-rst done", 32'(s_dn[0]), 32'd1);
    end
    reset  = 1'b0;
    vld[0] = 1'b0;
    check("rst no done", 32'(d_cnt), 32'd0);

    // Random valid/data on all instances with occasional resets.
    for (int r = 0; r < 800; r++) begin
      vld   = 3'($urandom);
      dat0  = 8'($urandom);
      dat1  = 8'($urandom);
      dat2  = 1'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick_cycle();
    end
    reset = 1'b0;
    vld   = '0;
    repeat (45) tick_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_serial_tx.md
# fsm_serial_tx

Byte-serial transmitter FSM producing the line format our serial receiver FSMs consume: one start bit (0), DATA_BITS data bits LSB first, an optional odd-parity bit, and one stop bit (1), with the line idling high. It accepts parallel words over a valid/ready handshake and holds each bit for BAUD_DIV clocks. It sits between a byte producer (test pattern source, FIFO) and the serial line.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame, 1..16.
- PARITY_EN, default 1: 1 inserts an odd-parity bit after the data bits; 0 omits it.
- BAUD_DIV, default 1: clocks per serial bit, ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  DATA_BITS  word to send; sampled only on an accept cycle.
- in_valid  in  1  producer has a word.
- in_ready  out  1  transmitter can accept; forced 0 while reset is high.
- out  out  1  serial line, registered; idle level 1.
- busy  out  1  registered; 1 from the cycle after accept through the last stop-bit cycle.
- done  out  1  registered; one-cycle pulse in the final clock of each stop bit.

## Operation
- Accept = in_valid && in_ready at a rising edge. in_data is latched into a shift register. The parity bit is computed at the same time as ~^in_data, so the total number of ones in data plus parity is odd.
- States:
  - IDLE: out=1, in_ready=1. On accept, go to START.
  - START: out=0.
  - DATA: out = shift[0], shifting right once per bit, DATA_BITS bits.
  - PARITY: out = latched parity; present only if PARITY_EN=1.
  - STOP: out=1.
- Each non-IDLE state lasts exactly BAUD_DIV clocks, counted by a baud counter that runs 0..BAUD_DIV-1. A bit counter 0..DATA_BITS-1 tracks DATA.
- Back-to-back frames: in_ready is also 1 in the final clock of STOP. An accept there goes straight to START with no idle bit. Without an accept, the FSM returns to IDLE.
- in_valid high while in_ready=0 is ignored; the word is not consumed.
- Reset (any state, mid-frame included): next edge gives state IDLE, out=1, busy=0, done=0, counters 0. The in-flight frame is abandoned, not completed.
- in_data and in_valid are not required to be stable outside accept cycles.

## Timing
- Accept at edge k: out=0 (start bit) from edge k+1.
- Frame length F = (1 + DATA_BITS + PARITY_EN + 1) × BAUD_DIV clocks (11 for the defaults).
- The stop bit occupies the last BAUD_DIV clocks of the frame. done=1 for exactly one clock, the last one. busy falls at the edge ending the frame unless a back-to-back accept occurred.
- Throughput with continuous in_valid: one word per F clocks, no gap.
- Reset values: out=1, busy=0, done=0. in_ready=0 during reset and 1 in the first cycle after reset deasserts.

## Structure
- Shared package fsm_serial_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - line constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - frame-length function frame_clks(DATA_BITS, PARITY_EN, BAUD_DIV). The receiver reuses this package.
- One sub-module, baud_tick. It is a counter that emits a tick every BAUD_DIV clocks and restarts on a clear input. The FSM advances bits only on a tick.

## Test plan
- Defaults, reset then in_data=0x4B with one valid pulse → out from the next cycle is 0,1,1,0,1,0,0,1,0, then parity 1, then stop 1. done is high in cycle 11 only. busy is high for cycles 1–11.
- in_data=0x00 then 0xFF, in_valid held high → second start bit in the cycle immediately after the first stop bit. Parity bits are 1 and 1. in_ready is high only in cycle 0 and cycle 11.
- BAUD_DIV=4, PARITY_EN=0, in_data=0xA5 → each bit held 4 clocks, frame 40 clocks, no parity slot, done in clock 40.
- Reset asserted in the 5th data bit of 0x3C → out=1 and busy=0 on the next edge. No done pulse. A new word accepted afterwards transmits correctly.
- in_valid toggling randomly while busy, with in_data changing → transmitted frame equals the word latched at accept. No extra accepts occur.
- DATA_BITS=1, in_data=1 → out 0,1,0(parity),1. Frame is 4 clocks.
